// File: rtl/frog_player_ctrl.sv
// Player-side controller for the frog crossing game: debounces the start and
// direction switches, moves the frog on the grid, scores crossings and detects car hits.
module frog_player_ctrl #(
  parameter int c_GAME_WIDTH  = 40,
  parameter int c_GAME_HEIGHT = 30,
  parameter int c_LIVES       = 3,
  parameter int c_DEBOUNCE    = 250000,
  parameter int c_HIT_HOLD    = 25000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Start,
  input  logic       i_Up,
  input  logic       i_Down,
  input  logic       i_Left,
  input  logic       i_Right,
  input  logic [5:0] i_Car_X,
  input  logic [5:0] i_Car_Y,
  input  logic [5:0] i_Col_Count_Div,
  input  logic [5:0] i_Row_Count_Div,
  output logic       o_Game_Active,
  output logic       o_Draw_Frog,
  output logic [5:0] o_Frog_X,
  output logic [5:0] o_Frog_Y,
  output logic [1:0] o_Lives,
  output logic [7:0] o_Score,
  output logic       o_Hit
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PLAY      = 2'd1;
  localparam logic [1:0] HIT       = 2'd2;
  localparam logic [1:0] GAME_OVER = 2'd3;

  localparam int DB_W   = (c_DEBOUNCE > 1) ? $clog2(c_DEBOUNCE) : 1;
  localparam int HOLD_W = (c_HIT_HOLD > 1) ? $clog2(c_HIT_HOLD) : 1;

  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(c_DEBOUNCE - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(c_HIT_HOLD - 1);
  localparam logic [5:0]        X_START    = 6'(c_GAME_WIDTH / 2);
  localparam logic [5:0]        Y_START    = 6'(c_GAME_HEIGHT - 1);
  localparam logic [5:0]        X_MAX      = 6'(c_GAME_WIDTH - 1);
  localparam logic [5:0]        Y_MAX      = 6'(c_GAME_HEIGHT - 1);
  localparam logic [1:0]        LIVES_INIT = 2'(c_LIVES);

  // Switch bit order: 0 start, 1 up, 2 down, 3 left, 4 right.
  logic [4:0] raw_sw;
  logic [4:0] sync_a;
  logic [4:0] sync_b;
  logic [4:0] rise;

  assign raw_sw = {i_Right, i_Left, i_Down, i_Up, i_Start};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two synchronizer stages.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw_sw;
      sync_b <= sync_a;
    end
  end

  // Level is accepted only after c_DEBOUNCE consecutive samples that disagree
  // with it; the rise pulse marks an accepted 0->1 change.
  for (genvar g = 0; g < 5; g++) begin : g_debounce
    logic [DB_W-1:0] cnt;
    logic            level;
    logic            rise_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        cnt    <= '0;
        level  <= 1'b0;
        rise_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        if (sync_b[g] == level) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          cnt    <= '0;
          level  <= sync_b[g];
          rise_q <= sync_b[g];
        end else begin
          cnt <= cnt + DB_W'(1);
        end
      end
    end

    assign rise[g] = rise_q;
  end

  logic start_rise;
  logic up_rise;
  logic down_rise;
  logic left_rise;
  logic right_rise;

  assign start_rise = rise[0];
  assign up_rise    = rise[1];
  assign down_rise  = rise[2];
  assign left_rise  = rise[3];
  assign right_rise = rise[4];

  logic [1:0]        state,   state_d;
  logic [5:0]        frog_x,  frog_x_d;
  logic [5:0]        frog_y,  frog_y_d;
  logic [1:0]        lives,   lives_d;
  logic [7:0]        score,   score_d;
  logic [HOLD_W-1:0] hit_cnt, hit_cnt_d;
  logic              hit_d;
  logic              collide;

  assign collide = (frog_x == i_Car_X) && (frog_y == i_Car_Y);

  // NOTE: every variable gets a default at the top of always_comb, so paths
  // that do not assign it cannot infer a latch.
  always_comb begin
    state_d   = state;
    frog_x_d  = frog_x;
    frog_y_d  = frog_y;
    lives_d   = lives;
    score_d   = score;
    hit_cnt_d = hit_cnt;
    hit_d     = 1'b0;

    case (state)
      IDLE: begin
        if (start_rise) begin
          state_d  = PLAY;
          lives_d  = LIVES_INIT;
          score_d  = '0;
          frog_x_d = X_START;
          frog_y_d = Y_START;
        end
      end

      PLAY: begin
        if (collide) begin
          state_d   = HIT;
          hit_d     = 1'b1;
          lives_d   = (lives != 2'd0) ? lives - 2'd1 : 2'd0;
          frog_x_d  = X_START;
          frog_y_d  = Y_START;
          hit_cnt_d = '0;
        end else if (frog_y == 6'd0) begin
          score_d  = (score == 8'hFF) ? score : score + 8'd1;
          frog_x_d = X_START;
          frog_y_d = Y_START;
        end else if (up_rise) begin
          frog_y_d = frog_y - 6'd1;
        end else if (down_rise) begin
          if (frog_y != Y_MAX) frog_y_d = frog_y + 6'd1;
        end else if (left_rise) begin
          if (frog_x != 6'd0) frog_x_d = frog_x - 6'd1;
        end else if (right_rise) begin
          if (frog_x != X_MAX) frog_x_d = frog_x + 6'd1;
        end
      end

      HIT: begin
        if (hit_cnt == HOLD_LAST) begin
          hit_cnt_d = '0;
          state_d   = (lives == 2'd0) ? GAME_OVER : PLAY;
        end else begin
          hit_cnt_d = hit_cnt + HOLD_W'(1);
        end
      end

      GAME_OVER: begin
        if (start_rise) begin
          state_d  = PLAY;
          lives_d  = LIVES_INIT;
          score_d  = '0;
          frog_x_d = X_START;
          frog_y_d = Y_START;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state         <= IDLE;
      frog_x        <= X_START;
      frog_y        <= Y_START;
      lives         <= LIVES_INIT;
      score         <= '0;
      hit_cnt       <= '0;
      o_Hit         <= 1'b0;
      o_Game_Active <= 1'b0;
      o_Draw_Frog   <= 1'b0;
    end else begin
      state         <= state_d;
      frog_x        <= frog_x_d;
      frog_y        <= frog_y_d;
      lives         <= lives_d;
      score         <= score_d;
      hit_cnt       <= hit_cnt_d;
      o_Hit         <= hit_d;
      o_Game_Active <= (state_d == PLAY);
      o_Draw_Frog   <= (i_Col_Count_Div == frog_x) && (i_Row_Count_Div == frog_y);
    end
  end

  assign o_Frog_X = frog_x;
  assign o_Frog_Y = frog_y;
  assign o_Lives  = lives;
  assign o_Score  = score;

endmodule
